// File: rtl/simon_out_buffer.sv
// SIMON_128128 result capture stage: acks each core result once and
// queues {enc_dec, block} in a small FIFO toward a valid/ready consumer.
module simon_out_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                doneData,
  input  logic [1:0][N-1:0]   outData,
  input  logic                enc_dec,
  output logic                readData,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0][N-1:0]   out_block,
  output logic                out_dir,
  output logic [AW:0]         count
);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  typedef logic [2*N:0] entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t         state_q, state_d;
  logic           rd_data_q, rd_data_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];

  logic           pop;
  logic           push;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  // A full FIFO still accepts when its head leaves on the same edge.
  assign push = (state_q == IDLE) & doneData &
                ((count_q != FULL) | pop);

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (push) begin
          state_d   = ACK;
          rd_data_d = 1'b1;
        end
      end
      ACK: begin
        if (!doneData) begin
          state_d   = IDLE;
          rd_data_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        rd_data_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {enc_dec, outData};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case (1'b1)
      (push & ~pop): count_d = count_q + 1'b1;
      (pop & ~push): count_d = count_q - 1'b1;
      default:       count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q   <= IDLE;
      rd_data_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign readData             = rd_data_q;
  assign count                = count_q;
  assign {out_dir, out_block} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_simon_out_buffer.sv
// Scoreboard bench for simon_out_buffer: a driver plays the core,
// a monitor checks every presented head against the expected queue.
module tb_simon_out_buffer;

  localparam int N  = 64;
  localparam int AW = 2;

  logic              clk = 1'b0;
  logic              nR = 1'b0;
  logic              doneData = 1'b0;
  logic [1:0][N-1:0] outData = '0;
  logic              enc_dec = 1'b0;
  logic              readData;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [1:0][N-1:0] out_block;
  logic              out_dir;
  logic [AW:0]       count;

  logic [128:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int n_pop = 0;
  bit wrap_on = 0;
  int max_cnt = 0;

  simon_out_buffer #(.N(N), .DEPTH(4), .AW(AW)) dut (
    .clk(clk), .nR(nR), .doneData(doneData), .outData(outData),
    .enc_dec(enc_dec), .readData(readData), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .out_dir(out_dir),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [128:0] act,
                     input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] b, input logic d);
    step();
    doneData = 1'b1;
    outData  = b;
    enc_dec  = d;
    exp_q.push_back({d, b});
  endtask

  task automatic wait_rd(input logic v, input int budget,
                         input string nm);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (readData === v) break;
    end
    chk(nm, readData, v);
  endtask

  task automatic send(input logic [127:0] b, input logic d);
    start(b, d);
    wait_rd(1'b1, 20, "send_ack");
    step();
    doneData = 1'b0;
    wait_rd(1'b0, 20, "send_release");
  endtask

  task automatic drain_all();
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (count == 0) break;
    end
    chk("drain_count", count, 0);
    step();
    out_ready = 1'b0;
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (nR && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("head_unexpected", out_valid, 1'b0);
      end else begin
        chk("head_block", out_block, exp_q[0][127:0]);
        chk("head_dir", out_dir, exp_q[0][128]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wrap_on && int'(count) > max_cnt) max_cnt = int'(count);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v;
    int p0;
    #1;
    chk("rst_readData", readData, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_out_dir", out_dir, 0);
    #12;
    nR = 1'b1;

    v = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
    start(v, 1'b1);
    @(negedge clk);
    chk("single_pre_ack", readData, 0);
    @(negedge clk);
    chk("single_ack", readData, 1);
    chk("single_valid", out_valid, 1);
    chk("single_count", count, 1);
    chk("single_block", out_block, v);
    chk("single_dir", out_dir, 1);
    step();
    step();
    @(negedge clk);
    chk("single_ack_hold", readData, 1);
    doneData = 1'b0;
    @(negedge clk);
    chk("single_ack_fall", readData, 0);
    drain_all();

    start(rnd_blk(), 1'($urandom_range(0, 1)));
    wait_rd(1'b1, 10, "held_ack");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_readData", readData, 1);
      chk("held_count", count, 1);
    end
    step();
    doneData = 1'b0;
    wait_rd(1'b0, 10, "held_release");
    chk("held_count_end", count, 1);
    drain_all();

    for (int k = 1; k <= 4; k++) send(128'(k), 1'(k & 1));
    @(negedge clk);
    chk("fill_count", count, 4);
    start(128'd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_no_ack", readData, 0);
      chk("full_count", count, 4);
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("swap_ack", readData, 1);
    chk("swap_count", count, 4);
    chk("swap_head", out_block, 2);
    step();
    doneData = 1'b0;
    wait_rd(1'b0, 10, "swap_release");
    drain_all();
    chk("fill_order_queue", 32'(exp_q.size()), 0);

    p0 = n_pop;
    max_cnt = 0;
    step();
    out_ready = 1'b1;
    wrap_on = 1;
    for (int k = 0; k < 10; k++) send(rnd_blk(), 1'($urandom_range(0, 1)));
    repeat (3) @(negedge clk);
    wrap_on = 0;
    chk("wrap_pops", 32'(n_pop - p0), 10);
    chk("wrap_max_le1", 1'(max_cnt <= 1), 1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_pop_count", count, 0);
      chk("empty_pop_valid", out_valid, 0);
    end
    step();
    out_ready = 1'b0;
    v = rnd_blk();
    send(v, 1'b0);
    @(negedge clk);
    chk("post_empty_block", out_block, v);
    chk("post_empty_count", count, 1);

    start(rnd_blk(), 1'b1);
    wait_rd(1'b1, 10, "mid_ack");
    chk("mid_count", count, 2);
    #2;
    nR = 1'b0;
    #1;
    chk("mid_rst_readData", readData, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    doneData = 1'b0;
    exp_q.delete();
    step();
    nR = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_rst_count", count, 0);
    chk("after_rst_readData", readData, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
